hilo_commit_buf: RTL and testbench

- Parametrised HI/LO register unit for the MIPS datapath.
- Speculative HI/LO writes from EX (mult/div/MTHI/MTLO) enter a small in-order pending buffer. They update architectural HI/LO only when the owning instruction retires.
- An exception flush discards all uncommitted writes.
- Reads (MFHI/MFLO) see a forwarded view: the youngest pending value per half, else the architectural value.

---
 rtl/hilo_commit_buf_if.sv | 31 +++
 rtl/hilo_commit_buf.sv | 103 ++++++++++
 tb/tb_hilo_commit_buf.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_commit_buf_if.sv
// HI/LO write, commit and read bundle between the EX/WB pipeline and the HI/LO unit.
interface hilo_commit_buf_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             wr_valid_i;
  logic [1:0]       wr_cfg_i;
  logic [WIDTH-1:0] hi_i;
  logic [WIDTH-1:0] lo_i;
  logic             wr_ready_o;
  logic             commit_i;
  logic             flush_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic [WIDTH-1:0] arch_hi_o;
  logic [WIDTH-1:0] arch_lo_o;
  logic [CW-1:0]    pend_cnt_o;
  logic             err_o;

  modport master (
    output wr_valid_i, wr_cfg_i, hi_i, lo_i, commit_i, flush_i,
    input  wr_ready_o, hi_o, lo_o, arch_hi_o, arch_lo_o, pend_cnt_o, err_o
  );

  modport slave (
    input  wr_valid_i, wr_cfg_i, hi_i, lo_i, commit_i, flush_i,
    output wr_ready_o, hi_o, lo_o, arch_hi_o, arch_lo_o, pend_cnt_o, err_o
  );
endinterface

// File: rtl/hilo_commit_buf.sv
// MIPS HI/LO register unit: speculative writes queue in an in-order buffer and
// reach architectural HI/LO on retirement; reads see the youngest pending value.
module hilo_commit_buf #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  hilo_commit_buf_if.slave  bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [1:0]       cfg_q [DEPTH];
  logic [WIDTH-1:0] hi_q  [DEPTH];
  logic [WIDTH-1:0] lo_q  [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] arch_hi_q;
  logic [WIDTH-1:0] arch_lo_q;
  logic             ready_q;
  logic             err_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fwd_hi;
  logic [WIDTH-1:0] fwd_lo;
  logic [PW-1:0]    idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // A flush kills any same-cycle push; the retiring head still pops.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    cnt_nxt = cnt_q;
    pop  = bus.commit_i && (cnt_q != '0);
    push = bus.wr_valid_i && ready_q && (bus.wr_cfg_i != 2'b00) && !bus.flush_i;
    if (bus.flush_i) cnt_nxt = '0;
    else             cnt_nxt = cnt_q + CW'(push) - CW'(pop);
  end

  // Oldest-to-youngest scan so the last matching entry per half wins.
  always_comb begin
    fwd_hi = arch_hi_q;
    fwd_lo = arch_lo_q;
    idx    = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (CW'(k) < cnt_q) begin
        idx = PW'((int'(head_q) + k) % int'(DEPTH));
        if (cfg_q[idx][1]) fwd_hi = hi_q[idx];
        if (cfg_q[idx][0]) fwd_lo = lo_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        cfg_q[i] <= 2'b00;
        hi_q[i]  <= '0;
        lo_q[i]  <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      arch_hi_q <= RESET_VAL;
      arch_lo_q <= RESET_VAL;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      err_q   <= bus.commit_i && (cnt_q == '0);
      cnt_q   <= cnt_nxt;
      ready_q <= (cnt_nxt < CW'(DEPTH));
      if (pop) begin
        if (cfg_q[head_q][1]) arch_hi_q <= hi_q[head_q];
        if (cfg_q[head_q][0]) arch_lo_q <= lo_q[head_q];
      end
      if (push) begin
        cfg_q[tail_q] <= bus.wr_cfg_i;
        hi_q[tail_q]  <= bus.hi_i;
        lo_q[tail_q]  <= bus.lo_i;
        tail_q        <= ptr_inc(tail_q);
      end
      if (bus.flush_i) head_q <= tail_q;
      else if (pop)    head_q <= ptr_inc(head_q);
    end
  end

  assign bus.wr_ready_o = ready_q;
  assign bus.hi_o       = fwd_hi;
  assign bus.lo_o       = fwd_lo;
  assign bus.arch_hi_o  = arch_hi_q;
  assign bus.arch_lo_o  = arch_lo_q;
  assign bus.pend_cnt_o = cnt_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_hilo_commit_buf.sv
// Directed bench for hilo_commit_buf: DEPTH=2/WIDTH=32 and DEPTH=4/WIDTH=64 instances.
module tb_hilo_commit_buf;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hilo_commit_buf_if #(.WIDTH(32), .DEPTH(2)) a_if ();
  hilo_commit_buf_if #(.WIDTH(64), .DEPTH(4)) b_if ();

  hilo_commit_buf #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  hilo_commit_buf #(.WIDTH(64), .DEPTH(4), .RESET_VAL(64'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drv(input logic v, input logic [1:0] cfg, input logic [31:0] hi,
                       input logic [31:0] lo, input logic cm, input logic fl);
    a_if.wr_valid_i = v;
    a_if.wr_cfg_i   = cfg;
    a_if.hi_i       = hi;
    a_if.lo_i       = lo;
    a_if.commit_i   = cm;
    a_if.flush_i    = fl;
  endtask

  task automatic b_drv(input logic v, input logic [1:0] cfg, input logic [63:0] hi,
                       input logic [63:0] lo, input logic cm);
    b_if.wr_valid_i = v;
    b_if.wr_cfg_i   = cfg;
    b_if.hi_i       = hi;
    b_if.lo_i       = lo;
    b_if.commit_i   = cm;
    b_if.flush_i    = 1'b0;
  endtask

  task automatic a_arch(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    chk({tag, "_arch_hi"}, 64'(a_if.arch_hi_o), 64'(hi));
    chk({tag, "_arch_lo"}, 64'(a_if.arch_lo_o), 64'(lo));
  endtask

  task automatic a_fwd(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    chk({tag, "_hi"}, 64'(a_if.hi_o), 64'(hi));
    chk({tag, "_lo"}, 64'(a_if.lo_o), 64'(lo));
  endtask

  logic [1:0]  e_cfg [10];
  logic [63:0] e_hi  [10];
  logic [63:0] e_lo  [10];
  logic [63:0] m_hi, m_lo, f_hi, f_lo;
  int          p, c;
  bit          do_push, do_cmt;

  initial begin
    rst_n = 1'b0;
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    b_drv(1'b0, 2'b00, 64'h0, 64'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a_arch("rst", 32'h0, 32'h0);
    a_fwd("rst", 32'h0, 32'h0);
    chk("rst_pend", 64'(a_if.pend_cnt_o), 64'd0);
    chk("rst_ready", 64'(a_if.wr_ready_o), 64'd1);
    chk("rst_err", 64'(a_if.err_o), 64'd0);
    chk("rst_b_ready", 64'(b_if.wr_ready_o), 64'd1);
    rst_n = 1'b1;
    step();

    // Single both-halves write, then commit
    a_drv(1'b1, 2'b11, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    a_fwd("push1", 32'h1111_1111, 32'h2222_2222);
    a_arch("push1", 32'h0, 32'h0);
    chk("push1_pend", 64'(a_if.pend_cnt_o), 64'd1);
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    a_arch("cmt1", 32'h1111_1111, 32'h2222_2222);
    chk("cmt1_pend", 64'(a_if.pend_cnt_o), 64'd0);
    a_fwd("cmt1", 32'h1111_1111, 32'h2222_2222);

    // Half writes fill the buffer; third write dropped
    a_drv(1'b1, 2'b10, 32'hA, 32'hDEAD, 1'b0, 1'b0);
    step();
    a_drv(1'b1, 2'b01, 32'h55, 32'hB, 1'b0, 1'b0);
    step();
    chk("full_ready", 64'(a_if.wr_ready_o), 64'd0);
    chk("full_pend", 64'(a_if.pend_cnt_o), 64'd2);
    a_fwd("full", 32'hA, 32'hB);
    a_drv(1'b1, 2'b11, 32'hFF, 32'hFF, 1'b0, 1'b0);
    step();
    chk("drop_pend", 64'(a_if.pend_cnt_o), 64'd2);
    a_fwd("drop", 32'hA, 32'hB);
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    a_arch("half1", 32'hA, 32'h2222_2222);
    chk("half1_pend", 64'(a_if.pend_cnt_o), 64'd1);
    a_fwd("half1", 32'hA, 32'hB);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    a_arch("half2", 32'hA, 32'hB);
    chk("half2_pend", 64'(a_if.pend_cnt_o), 64'd0);

    // Push+commit while full is refused; with room both happen
    a_drv(1'b1, 2'b11, 32'h1, 32'h2, 1'b0, 1'b0);
    step();
    a_drv(1'b1, 2'b11, 32'h3, 32'h4, 1'b0, 1'b0);
    step();
    a_drv(1'b1, 2'b11, 32'h5, 32'h5, 1'b1, 1'b0);
    step();
    chk("fullpp_pend", 64'(a_if.pend_cnt_o), 64'd1);
    chk("fullpp_ready", 64'(a_if.wr_ready_o), 64'd1);
    a_arch("fullpp", 32'h1, 32'h2);
    a_fwd("fullpp", 32'h3, 32'h4);
    a_drv(1'b1, 2'b11, 32'h6, 32'h7, 1'b1, 1'b0);
    step();
    chk("pp_pend", 64'(a_if.pend_cnt_o), 64'd1);
    a_arch("pp", 32'h3, 32'h4);
    a_fwd("pp", 32'h6, 32'h7);
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    a_arch("pp_drain", 32'h6, 32'h7);

    // Flush with same-cycle commit and push
    a_drv(1'b1, 2'b11, 32'h100, 32'h200, 1'b0, 1'b0);
    step();
    a_drv(1'b1, 2'b10, 32'h300, 32'h0, 1'b0, 1'b0);
    step();
    a_drv(1'b1, 2'b11, 32'h999, 32'h999, 1'b1, 1'b1);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    a_arch("flcm", 32'h100, 32'h200);
    a_fwd("flcm", 32'h100, 32'h200);
    chk("flcm_pend", 64'(a_if.pend_cnt_o), 64'd0);
    chk("flcm_ready", 64'(a_if.wr_ready_o), 64'd1);
    a_drv(1'b1, 2'b01, 32'h0, 32'h400, 1'b0, 1'b0);
    step();
    a_fwd("prefl", 32'h100, 32'h400);
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    a_arch("fl", 32'h100, 32'h200);
    a_fwd("fl", 32'h100, 32'h200);
    chk("fl_pend", 64'(a_if.pend_cnt_o), 64'd0);

    // cfg=0 is a no-op
    a_drv(1'b1, 2'b00, 32'h77, 32'h77, 1'b0, 1'b0);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("nop_pend", 64'(a_if.pend_cnt_o), 64'd0);
    a_fwd("nop", 32'h100, 32'h200);

    // Commit on empty buffer
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("err_hi", 64'(a_if.err_o), 64'd1);
    a_arch("err", 32'h100, 32'h200);
    chk("err_pend", 64'(a_if.pend_cnt_o), 64'd0);
    step();
    chk("err_lo", 64'(a_if.err_o), 64'd0);

    // DEPTH=4 overlapping push/commit stream with pointer wrap
    for (int i = 0; i < 10; i++) begin
      e_cfg[i] = (i % 3 == 0) ? 2'b10 : ((i % 3 == 1) ? 2'b01 : 2'b11);
      e_hi[i]  = 64'hA000_0000_0000_0000 + 64'(i);
      e_lo[i]  = 64'hB000_0000_0000_0000 + 64'(i);
    end
    m_hi = 64'h0;
    m_lo = 64'h0;
    p = 0;
    c = 0;
    for (int s = 0; s < 13; s++) begin
      do_push = (p < 10);
      do_cmt  = (s >= 3) && (c < p);
      if (do_push) b_drv(1'b1, e_cfg[p], e_hi[p], e_lo[p], do_cmt);
      else         b_drv(1'b0, 2'b00, 64'h0, 64'h0, do_cmt);
      step();
      if (do_cmt) begin
        if (e_cfg[c][1]) m_hi = e_hi[c];
        if (e_cfg[c][0]) m_lo = e_lo[c];
        c++;
      end
      if (do_push) p++;
      f_hi = m_hi;
      f_lo = m_lo;
      for (int j = c; j < p; j++) begin
        if (e_cfg[j][1]) f_hi = e_hi[j];
        if (e_cfg[j][0]) f_lo = e_lo[j];
      end
      chk($sformatf("b_arch_hi[%0d]", s), b_if.arch_hi_o, m_hi);
      chk($sformatf("b_arch_lo[%0d]", s), b_if.arch_lo_o, m_lo);
      chk($sformatf("b_hi[%0d]", s), b_if.hi_o, f_hi);
      chk($sformatf("b_lo[%0d]", s), b_if.lo_o, f_lo);
      chk($sformatf("b_pend[%0d]", s), 64'(b_if.pend_cnt_o), 64'(p - c));
    end
    b_drv(1'b0, 2'b00, 64'h0, 64'h0, 1'b0);
    chk("b_final_hi", b_if.arch_hi_o, 64'hA000_0000_0000_0009);
    chk("b_final_lo", b_if.arch_lo_o, 64'hB000_0000_0000_0008);

    // Async reset while an entry is pending
    a_drv(1'b1, 2'b11, 32'h77, 32'h88, 1'b0, 1'b0);
    step();
    a_drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_arst_pend", 64'(a_if.pend_cnt_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    a_arch("arst", 32'h0, 32'h0);
    a_fwd("arst", 32'h0, 32'h0);
    chk("arst_pend", 64'(a_if.pend_cnt_o), 64'd0);
    chk("arst_ready", 64'(a_if.wr_ready_o), 64'd1);
    chk("arst_b_hi", b_if.arch_hi_o, 64'h0);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
